nes_host_ctrl: RTL and testbench
================================

// Module: nes_host_ctrl
// PURPOSE
//  Host-command controller between the HPS-facing register port and the 6502 CPU core plus its memory.
//  Decodes 16-bit host words {op[7:0], data[7:0]}.
//  Runs the CPU reset / run / pause / single-step FSM and arbitrates the single-port memory (CPU or host).
//  Keeps a run-cycle counter and sticky status.
//  Replaces the ad-hoc op decode in the NES top level.
// PARAMETERS
//  ADDR_W        16  memory / CPU address width
//  DATA_W        8   memory / CPU data width
//  RESET_CYCLES  8   clocks cpu_reset is held high per reset (>=1)
//  CNT_W         32  run-cycle counter width
// PORTS
//  clk             in   1       system clock
//  reset           in   1       synchronous, active-high reset
//  host_cs         in   1       host chipselect; command accepted when host_cs & host_write & !host_busy
//  host_write      in   1       host write strobe
//  host_addr       in   ADDR_W  memory address for WRITE_MEM/READ_MEM
//  host_writedata  in   16      [15:8] op, [DATA_W-1:0] data
//  host_readdata   out  DATA_W  result register (mem read data or status byte)
//  host_busy       out  1       command in progress; new commands ignored
//  cpu_reset       out  1       CPU reset
//  cpu_ready       out  1       CPU clock enable
//  cpu_addr        in   ADDR_W  CPU address
//  cpu_write       in   1       CPU write strobe
//  cpu_dout        in   DATA_W  CPU write data
//  cpu_sync        in   1       CPU opcode-fetch cycle
//  cpu_din         out  DATA_W  = mem_rdata (combinational)
//  mem_addr        out  ADDR_W  memory address (combinational mux)
//  mem_write       out  1       memory write enable
//  mem_wdata       out  DATA_W  memory write data
//  mem_rdata       in   DATA_W  memory read data, valid 1 clk after mem_addr
//  cycle_count     out  CNT_W   clocks with cpu_ready=1 since last RESET op; wraps
// BEHAVIOUR
//  Ops: 0 RESET, 1 RUN, 2 PAUSE, 3 WRITE_MEM, 4 READ_MEM, 5 STEP, 6 READ_STATUS, 7 CLR_ERR;
//   other values are unknown ops: set err.
//  FSM states: S_RST, S_PAUSE, S_RUN, S_STEP, S_HWR, S_HRD1, S_HRD2.
//   cpu_ready = (S_RUN|S_STEP); cpu_reset = (S_RST).
//  reset: state S_RST, rst counter=RESET_CYCLES-1, host_readdata=0, err=0, cycle_count=0.
//   Outputs: cpu_reset=1, cpu_ready=0, mem_write=0, host_busy=1.
//  S_RST: decrement counter; at 0 go to S_PAUSE.
//   RESET op from any state: reload counter, clear cycle_count, enter S_RST.
//  S_PAUSE: accepts all ops; RUN->S_RUN, STEP->S_STEP, WRITE_MEM->S_HWR, READ_MEM->S_HRD1.
//  S_RUN: accepts RESET, PAUSE (->S_PAUSE next edge), READ_STATUS, CLR_ERR.
//   WRITE_MEM / READ_MEM / STEP are ignored and set err.
//  S_STEP: first cycle ignores cpu_sync.
//   Afterwards, the first cycle with cpu_sync=1 -> S_PAUSE; the CPU halts at the next opcode fetch.
//  S_HWR: one cycle; mem_addr=host_addr latched, mem_wdata=data latched, mem_write=1; ->S_PAUSE.
//  S_HRD1: drive latched address. S_HRD2: host_readdata<=mem_rdata, ->S_PAUSE.
//   Read latency: 2 clocks after command.
//  Memory mux: S_HWR/S_HRD* -> host; all other states -> CPU (mem_write = cpu_write & cpu_ready).
//  host_busy = state in {S_RST, S_STEP, S_HWR, S_HRD1, S_HRD2}. Commands while busy are dropped.
//   A dropped command does NOT set err, except RESET, which is always accepted.
//  READ_STATUS: host_readdata <= {state[2:0], err, bp_hit, 3'b0} next edge; no state change.
//  cycle_count: +1 each clk with cpu_ready=1; wraps at 2^CNT_W-1 -> 0.
// CONFIGURATION
//  NES_BREAKPOINT_EN defined:
//   op 8 loads the breakpoint from host_addr and arms it.
//   In S_RUN/S_STEP, cpu_sync & cpu_addr==bp & armed -> S_PAUSE and set sticky bp_hit.
//   bp_hit is cleared by RUN/STEP/RESET.
//  NES_BREAKPOINT_EN undefined: op 8 is an unknown op; bp_hit reads 0; no breakpoint register.
// STRUCTURE
//  nes_pkg: op enum nes_op_e, state enum nes_state_e, STATUS bit positions.
//  No sub-module; the mux is kept in the same file.
// TESTING
//  Reset, RESET_CYCLES=8 -> cpu_reset high for 8 clks then S_PAUSE; busy=0, cycle_count=0.
//  WRITE_MEM addr=0x8000 data=0xA9 then READ_MEM 0x8000 -> mem_write pulse 1 clk; readdata=0xA9 2 clks after read cmd.
//  RUN, 100 clks, PAUSE -> cycle_count=100 (±1 for pause edge); cpu_ready low next edge.
//  STEP from S_PAUSE with CPU model emitting sync every 3 clks -> cpu_ready high exactly until the next sync; S_PAUSE after.
//  WRITE_MEM during S_RUN -> memory untouched; READ_STATUS returns err=1; CLR_ERR then err=0.
//  NES_BREAKPOINT_EN: bp=0xC004, RUN -> pause on the sync cycle at 0xC004; READ_STATUS shows bp_hit=1.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types for the NES host-command controller: host opcodes, FSM states
// and status-byte bit positions.
package nes_pkg;

  typedef enum logic [7:0] {
    OP_RESET       = 8'd0,
    OP_RUN         = 8'd1,
    OP_PAUSE       = 8'd2,
    OP_WRITE_MEM   = 8'd3,
    OP_READ_MEM    = 8'd4,
    OP_STEP        = 8'd5,
    OP_READ_STATUS = 8'd6,
    OP_CLR_ERR     = 8'd7,
    OP_SET_BP      = 8'd8
  } nes_op_e;

  // Encoding is visible to the host through the status byte.
  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_PAUSE = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HWR   = 3'd4,
    S_HRD1  = 3'd5,
    S_HRD2  = 3'd6
  } nes_state_e;

  localparam int ST_STATE_LSB = 5;
  localparam int ST_ERR       = 4;
  localparam int ST_BP_HIT    = 3;

endpackage

// File: rtl/nes_host_ctrl.sv
// Host-command controller: CPU reset/run/pause/step FSM, single-port memory
// arbitration, run-cycle counter and sticky status. Optional breakpoint: NES_BREAKPOINT_EN.
module nes_host_ctrl
  import nes_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int RESET_CYCLES = 8,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_cs,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [15:0]       host_writedata,
  output logic [DATA_W-1:0] host_readdata,
  output logic              host_busy,
  output logic              cpu_reset,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_dout,
  input  logic              cpu_sync,
  output logic [DATA_W-1:0] cpu_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  nes_state_e        state, state_d;
  nes_op_e           op;
  logic [RC_W-1:0]   rst_cnt;
  logic              err, bp_hit, step_first;
  logic [ADDR_W-1:0] haddr_q;
  logic [DATA_W-1:0] hdata_q;
  logic [7:0]        status;
  logic              cmd, host_side;
  logic              do_reset, set_err, clr_err, rd_status, latch_host;
  logic              clr_bp, bp_trig, bp_match;

`ifdef NES_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_q;
  logic              armed, ld_bp;
  assign bp_match = cpu_sync & armed & (cpu_addr == bp_q);
`else
  assign bp_match = 1'b0;
`endif

  assign cmd    = host_cs & host_write;
  assign op     = nes_op_e'(host_writedata[15:8]);
  assign status = {state, err, bp_hit, 3'b000};

  always_comb begin
    state_d    = state;
    do_reset   = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    rd_status  = 1'b0;
    latch_host = 1'b0;
    clr_bp     = 1'b0;
    bp_trig    = 1'b0;
`ifdef NES_BREAKPOINT_EN
    ld_bp      = 1'b0;
`endif
    case (state)
      S_RST: if (rst_cnt == '0) state_d = S_PAUSE;
      S_PAUSE: if (cmd) begin
        case (op)
          OP_RESET, OP_PAUSE: ;
          OP_RUN:         begin state_d = S_RUN;  clr_bp = 1'b1; end
          OP_STEP:        begin state_d = S_STEP; clr_bp = 1'b1; end
          OP_WRITE_MEM:   begin state_d = S_HWR;  latch_host = 1'b1; end
          OP_READ_MEM:    begin state_d = S_HRD1; latch_host = 1'b1; end
          OP_READ_STATUS: rd_status = 1'b1;
          OP_CLR_ERR:     clr_err = 1'b1;
`ifdef NES_BREAKPOINT_EN
          OP_SET_BP:      ld_bp = 1'b1;
`endif
          default:        set_err = 1'b1;
        endcase
      end
      S_RUN: begin
        if (bp_match) begin
          state_d = S_PAUSE;
          bp_trig = 1'b1;
        end
        if (cmd) begin
          case (op)
            OP_RESET, OP_RUN: ;
            OP_PAUSE:       state_d = S_PAUSE;
            OP_READ_STATUS: rd_status = 1'b1;
            OP_CLR_ERR:     clr_err = 1'b1;
`ifdef NES_BREAKPOINT_EN
            OP_SET_BP:      ld_bp = 1'b1;
`endif
            default:        set_err = 1'b1;
          endcase
        end
      end
      // The first step cycle may itself be a fetch; it must not end the step.
      S_STEP: if (!step_first && (cpu_sync || bp_match)) begin
        state_d = S_PAUSE;
        bp_trig = bp_match;
      end
      S_HWR:   state_d = S_PAUSE;
      S_HRD1:  state_d = S_HRD2;
      S_HRD2:  state_d = S_PAUSE;
      default: state_d = S_RST;
    endcase
    // RESET wins from every state, busy or not.
    if (cmd && op == OP_RESET) begin
      do_reset = 1'b1;
      clr_bp   = 1'b1;
      state_d  = S_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RST;
      rst_cnt       <= RC_W'(RESET_CYCLES - 1);
      err           <= 1'b0;
      bp_hit        <= 1'b0;
      step_first    <= 1'b0;
      host_readdata <= '0;
      cycle_count   <= '0;
    end else begin
      state      <= state_d;
      step_first <= (state_d == S_STEP) && (state != S_STEP);
      if (do_reset)            rst_cnt <= RC_W'(RESET_CYCLES - 1);
      else if (state == S_RST) rst_cnt <= rst_cnt - 1'b1;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (clr_bp)       bp_hit <= 1'b0;
      else if (bp_trig) bp_hit <= 1'b1;
      if (rd_status)             host_readdata <= DATA_W'(status);
      else if (state == S_HRD2)  host_readdata <= mem_rdata;
      if (do_reset)       cycle_count <= '0;
      else if (cpu_ready) cycle_count <= cycle_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_host) begin
      haddr_q <= host_addr;
      hdata_q <= host_writedata[DATA_W-1:0];
    end
  end

`ifdef NES_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (reset)      armed <= 1'b0;
    else if (ld_bp) armed <= 1'b1;
    if (ld_bp) bp_q <= host_addr;
  end
`endif

  assign cpu_ready = (state == S_RUN) || (state == S_STEP);
  assign cpu_reset = (state == S_RST);
  assign host_busy = (state != S_PAUSE) && (state != S_RUN);
  assign host_side = (state == S_HWR) || (state == S_HRD1) || (state == S_HRD2);

  // Memory mux: the host owns the port only during its own access states.
  assign mem_addr  = host_side ? haddr_q : cpu_addr;
  assign mem_wdata = host_side ? hdata_q : cpu_dout;
  assign mem_write = (state == S_HWR) || (cpu_write && cpu_ready);
  assign cpu_din   = mem_rdata;

endmodule

// File: tb/tb_nes_host_ctrl.sv
// Directed bench for nes_host_ctrl with a behavioural synchronous RAM and a
// tiny CPU model that fetches every "period" ready cycles.
module tb_nes_host_ctrl;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_cs = 1'b0, host_write = 1'b0;
  logic [15:0] host_addr = '0;
  logic [15:0] host_writedata = '0;
  logic [7:0]  host_readdata;
  logic        host_busy, cpu_reset, cpu_ready;
  logic [15:0] cpu_addr;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_sync;
  logic [7:0]  cpu_din;
  logic [15:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [31:0] cycle_count;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:65535];
  int          ph = 0;
  int          period = 3;
  logic [15:0] pc = 16'hC000;

  nes_host_ctrl #(.ADDR_W(16), .DATA_W(8), .RESET_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .host_cs(host_cs), .host_write(host_write),
    .host_addr(host_addr), .host_writedata(host_writedata),
    .host_readdata(host_readdata), .host_busy(host_busy),
    .cpu_reset(cpu_reset), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_write(cpu_write), .cpu_dout(cpu_dout), .cpu_sync(cpu_sync),
    .cpu_din(cpu_din), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // CPU model: one opcode fetch (sync) every "period" enabled cycles.
  always @(posedge clk) begin
    if (cpu_reset) begin
      ph <= 0;
      pc <= 16'hC000;
    end else if (cpu_ready) begin
      ph <= (ph == period - 1) ? 0 : ph + 1;
      pc <= pc + 16'd1;
    end
  end
  assign cpu_sync = (ph == 0);
  assign cpu_addr = pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_cmd(input logic [7:0] opc, input logic [7:0] data, input logic [15:0] a);
    @(negedge clk);
    host_cs = 1'b1;
    host_write = 1'b1;
    host_writedata = {opc, data};
    host_addr = a;
    @(negedge clk);
    host_cs = 1'b0;
    host_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (host_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, host_busy}, 32'd0);
  endtask

  task automatic count_high(output int n, input bit use_reset);
    n = 0;
    while ((use_reset ? cpu_reset : cpu_ready) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 1);
    check("rst_ready",     {31'd0, cpu_ready}, 0);
    check("rst_busy",      {31'd0, host_busy}, 1);
    check("rst_memwr",     {31'd0, mem_write}, 0);
    check("rst_rdata",     {24'd0, host_readdata}, 0);
    check("rst_cnt",       cycle_count, 0);
    reset = 1'b0;
    count_high(n, 1'b1);
    check("rst_len", n, 8);
    check("rst_done_busy", {31'd0, host_busy}, 0);
    check("rst_done_cnt",  cycle_count, 0);

    // Host write then read back.
    host_cmd(OP_WRITE_MEM, 8'hA9, 16'h8000);
    check("wr_pulse", {31'd0, mem_write}, 1);
    check("wr_addr",  {16'd0, mem_addr}, 32'h8000);
    check("wr_data",  {24'd0, mem_wdata}, 32'hA9);
    @(negedge clk);
    check("wr_pulse_end", {31'd0, mem_write}, 0);
    host_cmd(OP_READ_MEM, 8'h00, 16'h8000);
    check("rd_busy", {31'd0, host_busy}, 1);
    check("rd_addr", {16'd0, mem_addr}, 32'h8000);
    @(negedge clk);
    @(negedge clk);
    check("rd_data", {24'd0, host_readdata}, 32'hA9);
    check("rd_idle", {31'd0, host_busy}, 0);

    // Run for a known number of cycles.
    host_cmd(OP_RESET, 8'h00, 16'h0000);
    wait_idle("reset_op_idle");
    host_cmd(OP_RUN, 8'h00, 16'h0000);
    check("run_ready", {31'd0, cpu_ready}, 1);
    repeat (98) @(negedge clk);
    host_cmd(OP_PAUSE, 8'h00, 16'h0000);
    check("pause_ready", {31'd0, cpu_ready}, 0);
    check("run_count", cycle_count, 100);

    // Single steps: the model sits at phase 1, so each step spans 3 cycles.
    host_cmd(OP_STEP, 8'h00, 16'h0000);
    count_high(n, 1'b0);
    check("step1_len", n, 3);
    check("step1_idle", {31'd0, host_busy}, 0);
    check("step1_count", cycle_count, 103);
    host_cmd(OP_STEP, 8'h00, 16'h0000);
    count_high(n, 1'b0);
    check("step2_len", n, 3);
    check("step2_count", cycle_count, 106);

    // Memory ops while running are rejected and flag an error.
    host_cmd(OP_RUN, 8'h00, 16'h0000);
    host_cmd(OP_WRITE_MEM, 8'h55, 16'h8001);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("run_status", {24'd0, host_readdata}, 32'h50);
    host_cmd(OP_PAUSE, 8'h00, 16'h0000);
    host_cmd(OP_READ_MEM, 8'h00, 16'h8001);
    @(negedge clk);
    @(negedge clk);
    check("run_wr_ignored", {24'd0, host_readdata}, 32'h00);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("err_status", {24'd0, host_readdata}, 32'h30);
    host_cmd(OP_CLR_ERR, 8'h00, 16'h0000);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("clr_status", {24'd0, host_readdata}, 32'h20);

    // Commands while busy are dropped without raising err.
    host_cmd(OP_RESET, 8'h00, 16'h0000);
    host_cmd(8'hFF, 8'h00, 16'h0000);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("drop_rdata", {24'd0, host_readdata}, 32'h20);
    wait_idle("drop_idle");
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("drop_noerr", {24'd0, host_readdata}, 32'h20);

`ifdef NES_BREAKPOINT_EN
    period = 2;
    host_cmd(OP_RESET, 8'h00, 16'h0000);
    wait_idle("bp_reset_idle");
    host_cmd(OP_SET_BP, 8'h00, 16'hC004);
    host_cmd(OP_RUN, 8'h00, 16'h0000);
    n = 0;
    while (cpu_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_paused", {31'd0, cpu_ready}, 0);
    check("bp_count", cycle_count, 5);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("bp_status", {24'd0, host_readdata}, 32'h28);
    host_cmd(OP_RUN, 8'h00, 16'h0000);
    host_cmd(OP_PAUSE, 8'h00, 16'h0000);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("bp_cleared", {24'd0, host_readdata}, 32'h20);
`else
    host_cmd(OP_SET_BP, 8'h00, 16'hC004);
    host_cmd(OP_READ_STATUS, 8'h00, 16'h0000);
    check("op8_unknown", {24'd0, host_readdata}, 32'h30);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
